// File: rtl/rotate_right_seq_if.sv
// rotate_right_seq_if: request/result handshake bundle for the sequential right rotator
//   in_valid/in_ready/a/amt : request channel (master drives a, amt, in_valid)
//   out_valid/out_ready/y    : result channel (master drives out_ready)
//   busy                     : rotator is working on or holding a result
interface rotate_right_seq_if #(
  parameter int WIDTH = 16,
  parameter int AMT_W = $clog2(WIDTH)
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [AMT_W-1:0] amt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             busy;
  modport master (output in_valid, a, amt, out_ready, input in_ready, out_valid, y, busy);
  modport slave  (input in_valid, a, amt, out_ready, output in_ready, out_valid, y, busy);
endinterface

// File: rtl/rotate_right_seq.sv
// rotate_right_seq: rotates a word right one bit per clock, amt cycles, over valid/ready handshakes
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : slave side of rotate_right_seq_if (request in, result out, busy)
module rotate_right_seq #(
  parameter int WIDTH = 16,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input logic               clk,
  input logic               reset,
  rotate_right_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_data;
  logic [AMT_W-1:0] r_cnt;
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE)
      w_next = bus.in_valid ? ((bus.amt == '0) ? DONE : SHIFT) : IDLE;
    else if (r_state == SHIFT)
      w_next = (r_cnt == AMT_W'(1)) ? DONE : SHIFT;
    else
      w_next = bus.out_ready ? IDLE : DONE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && bus.in_valid) begin
        r_data <= bus.a;
        r_cnt  <= bus.amt;
      end else if (r_state == SHIFT) begin
        r_data <= {r_data[0], r_data[WIDTH-1:1]};
        r_cnt  <= r_cnt - 1'b1;
      end
    end
  end
  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.busy      = (r_state != IDLE);
  assign bus.y         = r_data;
endmodule

// File: tb/tb_rotate_right_seq.sv
// tb_rotate_right_seq: directed and randomized checks of rotate_right_seq
module tb_rotate_right_seq;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  rotate_right_seq_if #(.WIDTH(16), .AMT_W(4)) bus_if ();
  rotate_right_seq #(.WIDTH(16), .AMT_W(4)) dut (.clk(clk), .reset(reset), .bus(bus_if));
  always #5 clk = ~clk;

  function automatic logic [15:0] rotr(input logic [15:0] x, input logic [3:0] n);
    logic [31:0] t;
    t = {x, x} >> n;
    return t[15:0];
  endfunction

  function automatic logic [15:0] rotl(input logic [15:0] x, input logic [3:0] n);
    logic [31:0] t;
    t = {x, x} << n;
    return t[31:16];
  endfunction

  task automatic send(input logic [15:0] a_v, input logic [3:0] amt_v);
    bus_if.in_valid = 1'b1;
    bus_if.a = a_v;
    bus_if.amt = amt_v;
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!bus_if.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic take();
    bus_if.out_ready = 1'b1;
    @(posedge clk); #1;
    bus_if.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus_if.y !== 16'h0000 || bus_if.in_ready !== 1'b1 || bus_if.out_valid !== 1'b0 || bus_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle y=%h in_ready=%b out_valid=%b busy=%b required y=0000 1 0 0",
               bus_if.y, bus_if.in_ready, bus_if.out_valid, bus_if.busy);
    end
  endtask

  task automatic test_single(input logic [15:0] a_v, input logic [3:0] amt_v, input logic [15:0] exp_y);
    int lat;
    send(a_v, amt_v);
    checks++;
    if (bus_if.busy !== 1'b1 || bus_if.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL busy_after_accept busy=%b in_ready=%b required 1 0", bus_if.busy, bus_if.in_ready);
    end
    wait_done(lat);
    checks++;
    if (lat !== int'(amt_v) + 1) begin
      errors++;
      $display("FAIL latency a=%h amt=%0d got %0d required %0d", a_v, amt_v, lat, int'(amt_v) + 1);
    end
    checks++;
    if (bus_if.y !== exp_y) begin
      errors++;
      $display("FAIL result a=%h amt=%0d y=%h required %h", a_v, amt_v, bus_if.y, exp_y);
    end
    take();
    checks++;
    if (bus_if.in_ready !== 1'b1 || bus_if.out_valid !== 1'b0 || bus_if.y !== exp_y) begin
      errors++;
      $display("FAIL post_take in_ready=%b out_valid=%b y=%h required 1 0 %h",
               bus_if.in_ready, bus_if.out_valid, bus_if.y, exp_y);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    send(16'h00F0, 4'd4);
    bus_if.in_valid = 1'b1;
    bus_if.a = 16'hFFFF;
    bus_if.amt = 4'd9;
    wait_done(lat);
    checks++;
    if (lat !== 5 || bus_if.y !== 16'h000F) begin
      errors++;
      $display("FAIL bp_first lat=%0d y=%h required 5 000f", lat, bus_if.y);
    end
    for (int i = 0; i < 10; i++) begin
      bus_if.in_valid = i[0];
      @(posedge clk); #1;
      checks++;
      if (bus_if.out_valid !== 1'b1 || bus_if.y !== 16'h000F || bus_if.busy !== 1'b1 || bus_if.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle %0d out_valid=%b y=%h busy=%b in_ready=%b required 1 000f 1 0",
                 i, bus_if.out_valid, bus_if.y, bus_if.busy, bus_if.in_ready);
      end
    end
    bus_if.in_valid = 1'b0;
    take();
    checks++;
    if (bus_if.in_ready !== 1'b1 || bus_if.y !== 16'h000F) begin
      errors++;
      $display("FAIL bp_release in_ready=%b y=%h required 1 000f", bus_if.in_ready, bus_if.y);
    end
  endtask

  task automatic test_back_to_back();
    int e = 0;
    int acc1 = -1;
    int acc2 = -1;
    logic pre_ready;
    logic [15:0] y1 = 16'h0;
    logic got1 = 1'b0;
    int lat;
    bus_if.in_valid = 1'b1;
    bus_if.a = 16'h1357;
    bus_if.amt = 4'd3;
    bus_if.out_ready = 1'b1;
    while (acc2 < 0 && e < 40) begin
      pre_ready = bus_if.in_ready;
      @(posedge clk); #1;
      e++;
      if (pre_ready && bus_if.busy) begin
        if (acc1 < 0) begin
          acc1 = e;
          bus_if.a = 16'hC0DE;
          bus_if.amt = 4'd5;
        end else begin
          acc2 = e;
          bus_if.in_valid = 1'b0;
        end
      end
      if (bus_if.out_valid && !got1) begin
        y1 = bus_if.y;
        got1 = 1'b1;
      end
    end
    checks++;
    if (acc2 - acc1 !== 5) begin
      errors++;
      $display("FAIL b2b_spacing got %0d required 5", acc2 - acc1);
    end
    checks++;
    if (y1 !== 16'hE26A) begin
      errors++;
      $display("FAIL b2b_first y=%h required e26a", y1);
    end
    wait_done(lat);
    checks++;
    if (lat !== 6 || bus_if.y !== 16'hF606) begin
      errors++;
      $display("FAIL b2b_second lat=%0d y=%h required 6 f606", lat, bus_if.y);
    end
    @(posedge clk); #1;
    bus_if.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    send(16'h8001, 4'd7);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    checks++;
    if (bus_if.y !== 16'h0000 || bus_if.in_ready !== 1'b1 || bus_if.out_valid !== 1'b0 || bus_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid y=%h in_ready=%b out_valid=%b busy=%b required 0000 1 0 0",
               bus_if.y, bus_if.in_ready, bus_if.out_valid, bus_if.busy);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    test_single(16'hABCD, 4'd4, 16'hDABC);
  endtask

  task automatic test_random();
    logic [15:0] a_v;
    logic [3:0] amt_v;
    int lat;
    for (int i = 0; i < 1000; i++) begin
      a_v = 16'($urandom);
      amt_v = 4'($urandom_range(0, 15));
      send(a_v, amt_v);
      wait_done(lat);
      checks++;
      if (bus_if.y !== rotr(a_v, amt_v) || lat !== int'(amt_v) + 1) begin
        errors++;
        $display("FAIL rand a=%h amt=%0d y=%h lat=%0d required %h %0d",
                 a_v, amt_v, bus_if.y, lat, rotr(a_v, amt_v), int'(amt_v) + 1);
      end
      checks++;
      if (rotl(bus_if.y, amt_v) !== a_v) begin
        errors++;
        $display("FAIL rand_inverse a=%h amt=%0d rotl(y)=%h required %h", a_v, amt_v, rotl(bus_if.y, amt_v), a_v);
      end
      take();
    end
  endtask

  initial begin
    bus_if.in_valid = 1'b0;
    bus_if.a = '0;
    bus_if.amt = '0;
    bus_if.out_ready = 1'b0;
    test_reset();
    test_single(16'h1234, 4'd0, 16'h1234);
    test_single(16'h0001, 4'd1, 16'h8000);
    test_single(16'hABCD, 4'd4, 16'hDABC);
    test_single(16'h8001, 4'd15, 16'h0003);
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rotate_right_seq.md
# rotate_right_seq

Sequential 16-bit right rotator: accepts a data word and rotate amount over a valid/ready handshake, rotates right one bit position per clock, and returns the result over a second valid/ready handshake. It is the inverse companion of the combinational left rotator. Rotating a word left by n and then through this block by n returns the original word. It sits in small datapaths where area matters more than latency.

## Interface

- WIDTH, 16: data width in bits; must be a power of two ≥ 2.
- AMT_W, $clog2(WIDTH) (4 at default): rotate-amount width.

Ports:

- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  request present on a/amt.
- in_ready  output  1  block can accept a request.
- a  input  WIDTH  word to rotate.
- amt  input  AMT_W  right-rotate amount, 0..WIDTH-1.
- out_valid  output  1  y holds a finished result.
- out_ready  input  1  consumer takes the result.
- y  output  WIDTH  rotated result.
- busy  output  1  high in SHIFT or DONE.

## Operation

- States: IDLE, SHIFT, DONE. Registers: data (WIDTH), cnt (AMT_W), state.
- Outputs by state:
  - IDLE: in_ready=1, out_valid=0, busy=0.
  - SHIFT: in_ready=0, out_valid=0, busy=1.
  - DONE: in_ready=0, out_valid=1, busy=1.
- y = data at all times, as a register output with no combinational path from the inputs.
- IDLE with in_valid=1 (accept):
  - data<=a, cnt<=amt.
  - Next state is DONE if amt==0, otherwise SHIFT.
- IDLE with in_valid=0: hold all registers.
- SHIFT, every cycle:
  - data<={data[0], data[WIDTH-1:1]} (rotate right by 1).
  - cnt<=cnt-1.
  - If cnt==1, next state is DONE; otherwise stay in SHIFT.
- DONE:
  - Hold data.
  - out_ready=1 returns the block to IDLE.
  - out_ready=0 holds DONE, y, and out_valid indefinitely.
- Result: y = ({a,a} >> amt)[WIDTH-1:0]. Bits shifted out of bit 0 re-enter at bit WIDTH-1, and no bit is lost.
- in_valid in SHIFT or DONE is ignored. The upstream must hold a/amt until in_ready=1.
- a/amt changing after the accept edge has no effect on the result.
- After DONE returns to IDLE, y keeps the last result until the next accept.

## Timing

- Reset (asynchronous, takes effect immediately): state=IDLE, data=0, cnt=0. Therefore y=0, out_valid=0, busy=0, in_ready=1.
- Reset mid-SHIFT or mid-DONE aborts the operation. No partial result is presented.
- Latency: out_valid rises amt+1 clock edges after the accept edge, counting the accept edge. Range is 1 (amt=0) to WIDTH (amt=WIDTH-1).
- Throughput: a new request cannot be accepted in the same cycle the result is taken.
  - Minimum spacing between accepts is amt+2 cycles.
  - in_ready rises the cycle after the out_ready handshake edge.
- Handshakes complete only on rising edges where valid and ready are both 1.
- No outputs depend combinationally on in_valid or out_ready.

## Test plan

- Reset, then idle: y=0x0000, in_ready=1, out_valid=0, busy=0. Assert reset mid-SHIFT (a=0x8001, amt=7, after 3 cycles): all outputs return to reset values immediately, and a following request works normally.
- a=0x1234, amt=0 -> out_valid one cycle after accept, y=0x1234. a=0x0001, amt=1 -> out_valid 2 cycles after accept, y=0x8000.
- a=0xABCD, amt=4 -> y=0xDABC after 5 cycles. a=0x8001, amt=15 -> y=0x0003 after 16 cycles.
- Backpressure: a=0x00F0, amt=4, out_ready held low 10 cycles -> y=0x000F and out_valid held stable throughout. in_valid pulses during SHIFT/DONE are ignored.
- Back-to-back requests with out_ready=1: second accept occurs exactly amt+2 cycles after the first, and both results are correct.
- Random a and amt (≥1000): y equals the reference right rotation, and left-rotating y by amt restores a.
